// File: rtl/rr_route_scheduler.sv
// rr_route_scheduler: round-robin scheduler between four show-ahead input FIFOs
// and four output FIFOs. It grants at most one eligible head per cycle, pops the
// granted input combinationally, and pushes the registered word one cycle later
// to the output FIFO named by word bits [1:0].
// Optional feature macro: ARB_STATS_EN (per-input saturating grant counters).
//
// state  | meaning
// IDLE   | no grant last cycle, nothing in flight
// ACTIVE | a grant was made last cycle; its word is being pushed now
// DRAIN  | grants stopped; the last registered word has been pushed
module rr_route_scheduler #(
    parameter int DATA_WIDTH  = 10,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [3:0]               empty_in,
    input  logic [4*DATA_WIDTH-1:0]  head_data,
    input  logic [3:0]               almost_full,
    output logic [3:0]               pop,
    output logic [1:0]               select,
    output logic [3:0]               push,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     idle,
    input  logic                     stats_clr,
    output logic [4*COUNT_WIDTH-1:0] grant_cnt
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t                state, state_next;
    logic [1:0]            rr_ptr;
    logic [3:0]            elig;
    logic                  grant;
    logic [1:0]            gidx;
    logic [1:0]            cand;
    logic [DATA_WIDTH-1:0] gword;

    // An input is eligible when it has a head word and its destination can take it.
    always_comb begin
        elig = '0;
        for (int i = 0; i < 4; i++) begin
            elig[i] = !reset && enable && !empty_in[i]
                      && !almost_full[head_data[i*DATA_WIDTH +: 2]];
        end
    end

    // Search from rr_ptr upward; descending loop lets the nearest candidate win.
    always_comb begin
        grant = 1'b0;
        gidx  = rr_ptr;
        cand  = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr + 2'(k);
            if (elig[cand]) begin
                grant = 1'b1;
                gidx  = cand;
            end
        end
    end

    // Grant outputs toward the input FIFOs and the selected head word.
    always_comb begin
        gword  = head_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
        pop    = grant ? (4'b0001 << gidx) : 4'b0000;
        select = grant ? gidx : 2'd0;
        idle   = !grant && (push == 4'b0000);
    end

    // Output register stage and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            push     <= '0;
            data_out <= '0;
            rr_ptr   <= '0;
        end else if (grant) begin
            push     <= 4'b0001 << gword[1:0];
            data_out <= gword;
            rr_ptr   <= gidx + 2'd1;
        end else begin
            push     <= '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = grant ? ACTIVE : IDLE;
            ACTIVE:  state_next = grant ? ACTIVE : ((push != 4'b0000) ? DRAIN : IDLE);
            DRAIN:   state_next = grant ? ACTIVE : IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef ARB_STATS_EN
    logic [COUNT_WIDTH-1:0] cnt [4];

    // Saturating per-input grant counters; clear wins over increment.
    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (grant && (cnt[gidx] != {COUNT_WIDTH{1'b1}})) begin
            cnt[gidx] <= cnt[gidx] + COUNT_WIDTH'(1);
        end
    end

    // Pack counters onto the output bus.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < 4; i++) grant_cnt[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt[i];
    end
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign grant_cnt        = '0;
`endif

endmodule
